// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART TX FIFO arbiter: FSM encoding, FIFO sizing
// defaults taken from the UART FIFO constants, and a small index helper.
package uart_tx_arb_pkg;

   // UART transmit FIFO geometry; the arbiter defaults follow these.
   localparam int UART_FIFO_DEPTH     = 16;
   localparam int UART_FIFO_COUNTER_W = 5;

   localparam int ARB_FIFO_DEPTH = UART_FIFO_DEPTH;
   localparam int ARB_CNT_W      = UART_FIFO_COUNTER_W;

   // Requester index width (up to 8 requesters).
   localparam int ARB_ID_W = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } arb_state_t;

   // Index of the requester after idx, wrapping at nreq.
   function automatic logic [ARB_ID_W-1:0] f_wrap_inc(
      input logic [ARB_ID_W-1:0] idx,
      input int                  nreq
   );
      if (int'(idx) >= (nreq - 32'sd1)) begin
         return {ARB_ID_W{1'b0}};
      end else begin
         return idx + {{(ARB_ID_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker. The requester at i_ptr has the
// highest priority, then i_ptr+1, and so on, wrapping modulo NREQ.
module uart_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]     i_req,
   input  logic [ARB_ID_W-1:0] i_ptr,
   output logic [NREQ-1:0]     o_grant,
   output logic [ARB_ID_W-1:0] o_idx,
   output logic                o_any
);

   int w_best;
   int w_dist;

   // Pick the requesting index with the smallest rotated distance from i_ptr
   always_comb begin
      o_idx  = {ARB_ID_W{1'b0}};
      o_any  = 1'b0;
      w_best = NREQ;
      w_dist = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (i >= int'(i_ptr)) begin
            w_dist = i - int'(i_ptr);
         end else begin
            w_dist = i + NREQ - int'(i_ptr);
         end
         if (i_req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            o_idx  = ARB_ID_W'(i);
            o_any  = 1'b1;
         end else begin
            w_best = w_best;
         end
      end
   end

   // One-hot form of the chosen index
   always_comb begin
      o_grant = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         o_grant[i] = o_any & (o_idx == ARB_ID_W'(i));
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART TX FIFO arbiter: grants one byte source at a time for a whole packet
// and pushes its bytes into the TX FIFO without ever overrunning it.
// Build option: define UART_TX_ARB_PRIO_EN to give requester 0 strict
// priority at every arbitration point (others stay round-robin).
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int FIFO_DEPTH = ARB_FIFO_DEPTH,
   parameter int CNT_W      = ARB_CNT_W
) (
   input  logic                i_clk,
   input  logic                i_wb_rst_ni,
   input  logic                i_arb_en,
   input  logic                i_tx_reset,
   input  logic [CNT_W-1:0]    i_tf_count,
   input  logic [NREQ-1:0]     i_req_valid,
   input  logic [NREQ-1:0]     i_req_last,
   input  logic [8*NREQ-1:0]   i_req_data,
   output logic [NREQ-1:0]     o_req_ready,
   output logic                o_tf_push,
   output logic [7:0]          o_tf_data,
   output logic [2:0]          o_grant_id,
   output logic                o_busy
);

   localparam logic [CNT_W:0] LP_DEPTH = (CNT_W+1)'(FIFO_DEPTH);

   arb_state_t          r_state;
   arb_state_t          w_next_state;
   logic [ARB_ID_W-1:0] r_grant_id;
   logic [NREQ-1:0]     r_grant_oh;
   logic                r_busy;
   logic [ARB_ID_W-1:0] r_rr_ptr;
   logic                r_tf_push;
   logic [7:0]          r_tf_data;

   logic [CNT_W:0]      w_fill;
   logic                w_space_ok;
   logic                w_start;
   logic                w_hs;
   logic                w_hs_last;
   logic [7:0]          w_sel_data;

   logic [NREQ-1:0]     w_rr_req;
   logic [NREQ-1:0]     w_rr_oh;
   logic [ARB_ID_W-1:0] w_rr_idx;
   logic                w_rr_any;
   logic [NREQ-1:0]     w_win_oh;
   logic [ARB_ID_W-1:0] w_win_idx;
   logic                w_win_any;

   // The byte already in flight counts against free space; one extra bit avoids wrap
   assign w_fill     = {1'b0, i_tf_count} + {{CNT_W{1'b0}}, r_tf_push};
   assign w_space_ok = (w_fill < LP_DEPTH);

   uart_rr_pick #(
      .NREQ    (NREQ)
   ) u_pick (
      .i_req   (w_rr_req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_rr_oh),
      .o_idx   (w_rr_idx),
      .o_any   (w_rr_any)
   );

`ifdef UART_TX_ARB_PRIO_EN
   // Requester 0 is taken out of the rotation and wins outright whenever it asks
   always_comb begin
      w_rr_req    = i_req_valid;
      w_rr_req[0] = 1'b0;
      if (i_req_valid[0]) begin
         w_win_oh  = {{(NREQ-1){1'b0}}, 1'b1};
         w_win_idx = {ARB_ID_W{1'b0}};
      end else begin
         w_win_oh  = w_rr_oh;
         w_win_idx = w_rr_idx;
      end
      w_win_any = i_req_valid[0] | w_rr_any;
   end
`else
   // Pure round-robin across every requester
   always_comb begin
      w_rr_req  = i_req_valid;
      w_win_oh  = w_rr_oh;
      w_win_idx = w_rr_idx;
      w_win_any = w_rr_any;
   end
`endif

   // A new grant needs an idle arbiter, permission, a requester and FIFO room
   assign w_start = (r_state == S_IDLE) & i_arb_en & w_win_any & w_space_ok & ~i_tx_reset;

   // Handshake detection; ready already excludes tx_reset so it wins over a byte
   assign w_hs      = |(o_req_ready & i_req_valid);
   assign w_hs_last = |(o_req_ready & i_req_valid & i_req_last);

   // Byte mux driven by the latched one-hot grant
   always_comb begin
      w_sel_data = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant_oh[i]) begin
            w_sel_data = w_sel_data | i_req_data[8*i +: 8];
         end else begin
            w_sel_data = w_sel_data;
         end
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_wb_rst_ni) begin
      if (!i_wb_rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state decode; tx_reset returns to idle from anywhere
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_next_state = S_GRANT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_GRANT: begin
            if (i_tx_reset) begin
               w_next_state = S_IDLE;
            end else if (w_hs_last) begin
               w_next_state = S_GAP;
            end else begin
               w_next_state = S_GRANT;
            end
         end
         S_GAP: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // FSM outputs: only the granted requester sees ready, and only with FIFO room
   always_comb begin
      o_req_ready = {NREQ{1'b0}};
      if ((r_state == S_GRANT) && w_space_ok && !i_tx_reset) begin
         o_req_ready = r_grant_oh;
      end else begin
         o_req_ready = {NREQ{1'b0}};
      end
   end

   // Push strobe and data: one cycle after each accepted byte
   always_ff @(posedge i_clk or negedge i_wb_rst_ni) begin
      if (!i_wb_rst_ni) begin
         r_tf_push <= 1'b0;
         r_tf_data <= 8'h00;
      end else begin
         r_tf_push <= w_hs;
         r_tf_data <= w_hs ? w_sel_data : 8'h00;
      end
   end

   // Grant bookkeeping: latch winner, release on packet end or abort, advance pointer
   always_ff @(posedge i_clk or negedge i_wb_rst_ni) begin
      if (!i_wb_rst_ni) begin
         r_busy     <= 1'b0;
         r_grant_id <= {ARB_ID_W{1'b0}};
         r_grant_oh <= {NREQ{1'b0}};
         r_rr_ptr   <= {ARB_ID_W{1'b0}};
      end else if (i_tx_reset) begin
         r_busy     <= 1'b0;
         r_grant_id <= {ARB_ID_W{1'b0}};
         r_grant_oh <= {NREQ{1'b0}};
      end else if (w_start) begin
         r_busy     <= 1'b1;
         r_grant_id <= w_win_idx;
         r_grant_oh <= w_win_oh;
      end else if (w_hs_last) begin
         r_busy     <= 1'b0;
         r_grant_id <= {ARB_ID_W{1'b0}};
         r_grant_oh <= {NREQ{1'b0}};
         r_rr_ptr   <= f_wrap_inc(r_grant_id, NREQ);
      end else begin
         r_busy     <= r_busy;
         r_grant_id <= r_grant_id;
         r_grant_oh <= r_grant_oh;
         r_rr_ptr   <= r_rr_ptr;
      end
   end

   assign o_tf_push  = r_tf_push;
   assign o_tf_data  = r_tf_data;
   assign o_grant_id = r_grant_id;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: drivers push the expected FIFO
// byte/cycle on every handshake, a monitor pops and compares on tf_push.
module tb_uart_tx_arbiter;

   localparam int NREQ  = 2;
   localparam int CNT_W = 5;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   typedef struct {
      int r;
      int c;
   } hs_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              arb_en;
   logic              tx_reset;
   logic [CNT_W-1:0]  tf_count;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_last;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              tf_push;
   logic [7:0]        tf_data;
   logic [2:0]        grant_id;
   logic              busy;

   int   n_vec;
   int   n_err;
   int   cyc = 0;
   int   fifo_cnt = 0;
   logic drain_en;
   logic cnt_load;
   int   cnt_load_val;
   logic prev_busy = 1'b0;
   exp_t mon_e;
   exp_t exp_q[$];
   int   grant_log[$];
   hs_t  hs_log[$];
   int   hs_cnt;

   uart_tx_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
      .i_clk       (clk),
      .i_wb_rst_ni (rst_n),
      .i_arb_en    (arb_en),
      .i_tx_reset  (tx_reset),
      .i_tf_count  (tf_count),
      .i_req_valid (req_valid),
      .i_req_last  (req_last),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .o_tf_push   (tf_push),
      .o_tf_data   (tf_data),
      .o_grant_id  (grant_id),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Simple TX FIFO fill model: fills on push, drains one byte per cycle when enabled
   always @(posedge clk) begin
      if (cnt_load) fifo_cnt <= cnt_load_val;
      else fifo_cnt <= fifo_cnt + (tf_push ? 1 : 0) - ((drain_en && fifo_cnt > 0) ? 1 : 0);
   end
   assign tf_count = fifo_cnt[CNT_W-1:0];

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Monitor: scoreboard pop on every push, and log each new grant
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tf_push) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_push: got tf_data=0x%02h, expected no push", tf_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("push_data", int'(tf_data), int'(mon_e.data));
               chk("push_cycle", cyc, mon_e.cyc);
            end
         end
         if (rst_n && busy && !prev_busy) grant_log.push_back(int'(grant_id));
         prev_busy = busy;
      end
   end

   task automatic send_pkt(input int r, input int n, input logic [31:0] bytes, input bit end_pkt);
      int  waited;
      bit  done;
      for (int i = 0; i < n; i++) begin
         req_valid[r]        = 1'b1;
         req_data[8*r +: 8]  = bytes[8*i +: 8];
         req_last[r]         = end_pkt && (i == n - 1);
         done   = 1'b0;
         waited = 0;
         while (!done) begin
            @(negedge clk);
            if (req_ready[r]) begin
               chk("hs_grant_id", int'(grant_id), r);
               exp_q.push_back('{bytes[8*i +: 8], cyc + 1});
               hs_log.push_back('{r, cyc});
               done = 1'b1;
            end else if (waited >= 200) begin
               n_vec++;
               n_err++;
               $display("FAIL hs_timeout: requester %0d byte %0d never accepted", r, i);
               done = 1'b1;
            end else begin
               waited++;
            end
            @(posedge clk);
            #1;
         end
      end
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (k < 40 && (exp_q.size() != 0 || busy)) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic check_grants(input string name, input int n, input logic [15:0] ids);
      chk({name, "_count"}, grant_log.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < grant_log.size()) chk(name, grant_log[i], int'(ids[4*i +: 4]));
      end
      grant_log.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b1; arb_en = 1'b1; tx_reset = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0;
      drain_en = 1'b1; cnt_load = 1'b1; cnt_load_val = 0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_push", int'(tf_push), 0);
      chk("rst_data", int'(tf_data), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(req_ready), 0);
      @(negedge clk);
      rst_n = 1'b1; cnt_load = 1'b0;
      @(posedge clk); #1;

      // Two requesters at once, pointer at 0: whole packets, one gap cycle between
      hs_log.delete();
      fork
         send_pkt(0, 2, 32'h0000_1211, 1'b1);
         send_pkt(1, 2, 32'h0000_2221, 1'b1);
      join
      wait_idle();
      chk("t2_hs_count", hs_log.size(), 4);
      if (hs_log.size() == 4) begin
         chk("t2_order0", hs_log[0].r, 0);
         chk("t2_order1", hs_log[1].r, 0);
         chk("t2_order2", hs_log[2].r, 1);
         chk("t2_order3", hs_log[3].r, 1);
         chk("t2_gap_cycles", hs_log[2].c - hs_log[1].c, 3);
      end
      check_grants("t2_grants", 2, 16'h0010);

      // Single 3-byte packet from requester 0
      send_pkt(0, 3, 32'h0043_4241, 1'b1);
      chk("t1_busy_after_last", int'(busy), 0);
      chk("t1_grant_id_after_last", int'(grant_id), 0);
      chk("t1_ready_in_gap", int'(req_ready), 0);
      wait_idle();
      check_grants("t1_grants", 1, 16'h0000);

      // FIFO full, then exactly one slot at a time
      drain_en = 1'b0; cnt_load = 1'b1; cnt_load_val = 16;
      @(posedge clk); #1;
      cnt_load = 1'b0;
      fork
         send_pkt(0, 2, 32'h0000_6261, 1'b1);
         begin
            repeat (4) begin
               @(negedge clk);
               chk("t3_full_ready", int'(req_ready), 0);
               chk("t3_full_busy", int'(busy), 0);
            end
            @(posedge clk); #1;
            drain_en = 1'b1;
            @(posedge clk); #1;
            drain_en = 1'b0;
            hs_cnt = 0;
            repeat (8) begin
               @(negedge clk);
               hs_cnt += int'(req_ready[0] & req_valid[0]);
            end
            chk("t3_one_byte_at_15", hs_cnt, 1);
            chk("t3_grant_held", int'(busy), 1);
            @(posedge clk); #1;
            drain_en = 1'b1;
            @(posedge clk); #1;
            drain_en = 1'b0;
         end
      join
      drain_en = 1'b1;
      wait_idle();
      check_grants("t3_grants", 1, 16'h0000);

      // tx_reset after byte 2 of a 4-byte packet from requester 1
      send_pkt(1, 2, 32'h0000_7271, 1'b0);
      tx_reset = 1'b1;
      req_valid[1] = 1'b1; req_data[15:8] = 8'h73; req_last[1] = 1'b0;
      @(negedge clk);
      chk("t4_ready_with_reset", int'(req_ready), 0);
      @(posedge clk); #1;
      tx_reset = 1'b0;
      req_valid[1] = 1'b0;
      chk("t4_busy_after_reset", int'(busy), 0);
      chk("t4_grant_after_reset", int'(grant_id), 0);
      @(negedge clk);
      chk("t4_no_push_after_reset", int'(tf_push), 0);
      @(posedge clk); #1;
      send_pkt(1, 2, 32'h0000_7473, 1'b1);
      wait_idle();
      check_grants("t4_grants", 2, 16'h0011);

      // arb_en dropped mid-packet: packet completes, no new grant until re-enabled
      fork
         send_pkt(0, 3, 32'h0053_5251, 1'b1);
         begin
            repeat (2) @(posedge clk);
            #1;
            arb_en = 1'b0;
         end
      join
      fork
         send_pkt(1, 1, 32'h0000_0054, 1'b1);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("t5_no_grant_busy", int'(busy), 0);
               chk("t5_no_grant_ready", int'(req_ready), 0);
            end
            @(posedge clk); #1;
            arb_en = 1'b1;
         end
      join
      wait_idle();
      check_grants("t5_grants", 2, 16'h0010);

      // Both requesters always waiting: alternate, or requester 0 first with priority
      fork
         begin
            send_pkt(0, 1, 32'h0000_00A1, 1'b1);
            send_pkt(0, 1, 32'h0000_00A2, 1'b1);
         end
         begin
            send_pkt(1, 1, 32'h0000_00B1, 1'b1);
            send_pkt(1, 1, 32'h0000_00B2, 1'b1);
         end
      join
      wait_idle();
`ifdef UART_TX_ARB_PRIO_EN
      check_grants("t6_grants", 4, 16'h1100);
`else
      check_grants("t6_grants", 4, 16'h1010);
`endif

      // Reset asserted mid-packet clears everything at once
      req_valid[0] = 1'b1; req_data[7:0] = 8'hEE; req_last[0] = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_grant_id", int'(grant_id), 0);
      chk("mid_rst_push", int'(tf_push), 0);
      chk("mid_rst_ready", int'(req_ready), 0);
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_no_push_after", int'(tf_push), 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
